// File: rtl/fw_err_sched_pkg.sv
// Shared types and default parameters for the fixed-weight error-vector scheduler.
package fw_err_sched_pkg;

   localparam int unsigned M_DEF         = 13;
   localparam int unsigned WIDTH_DEF     = 32;
   localparam int unsigned DEPTH_DEF     = 144;
   localparam int unsigned E0_WIDTH_DEF  = 32;
   localparam int unsigned E0_DEPTH_DEF  = 144;
   localparam int unsigned TAU_DEF       = 96;
   localparam int unsigned MAX_RETRY_DEF = 15;
   localparam int unsigned RETRY_W       = 4;
   localparam int unsigned LOGW_DEF      = $clog2(DEPTH_DEF);
   localparam int unsigned LOGE0W_DEF    = $clog2(E0_DEPTH_DEF);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INIT     = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_START    = 3'd3,
      ST_GEN      = 3'd4,
      ST_VALID    = 3'd5,
      ST_FAIL     = 3'd6
   } state_e;

endpackage

// File: rtl/fw_err_sched_if.sv
// Control, generator-status and memory-read signals of the scheduler.
interface fw_err_sched_if
   import fw_err_sched_pkg::*;
#(
   parameter int unsigned LOGW   = LOGW_DEF,
   parameter int unsigned LOGE0W = LOGE0W_DEF
);
   logic               req_i;
   logic               release_i;
   logic               busy_o;
   logic               vec_valid_o;
   logic               fail_o;
   logic [RETRY_W-1:0] retry_cnt_o;
   logic               gen_init_mem_o;
   logic               gen_start_o;
   logic               loc_reseed_o;
   logic               gen_ready_i;
   logic               gen_done_i;
   logic               gen_collision_i;
   logic               c0_req_i;
   logic               c1_req_i;
   logic [LOGW-1:0]    c0_addr_i;
   logic [LOGW-1:0]    c1_addr_i;
   logic               c0_gnt_o;
   logic               c1_gnt_o;
   logic               c0_rvalid_o;
   logic               c1_rvalid_o;
   logic               rd_e_1_o;
   logic [LOGW-1:0]    rd_addr_e_1_o;
   logic               e0_req_i;
   logic [LOGE0W-1:0]  e0_addr_i;
   logic               rd_e_0_o;
   logic [LOGE0W-1:0]  rd_addr_e_0_o;

   modport slave (
      input  req_i, release_i, gen_ready_i, gen_done_i, gen_collision_i,
             c0_req_i, c1_req_i, c0_addr_i, c1_addr_i, e0_req_i, e0_addr_i,
      output busy_o, vec_valid_o, fail_o, retry_cnt_o, gen_init_mem_o, gen_start_o,
             loc_reseed_o, c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o,
             rd_e_1_o, rd_addr_e_1_o, rd_e_0_o, rd_addr_e_0_o
   );

   modport master (
      output req_i, release_i, gen_ready_i, gen_done_i, gen_collision_i,
             c0_req_i, c1_req_i, c0_addr_i, c1_addr_i, e0_req_i, e0_addr_i,
      input  busy_o, vec_valid_o, fail_o, retry_cnt_o, gen_init_mem_o, gen_start_o,
             loc_reseed_o, c0_gnt_o, c1_gnt_o, c0_rvalid_o, c1_rvalid_o,
             rd_e_1_o, rd_addr_e_1_o, rd_e_0_o, rd_addr_e_0_o
   );

endinterface

// File: rtl/fw_err_sched_rr_arb2.sv
// Two-client round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
   import fw_err_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   logic prio_q;
   logic prio_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   // Priority moves to the client that was not just served.
   always_comb begin
      prio_d = prio_q;
      if (gnt_o[0]) begin
         prio_d = 1'b1;
      end else if (gnt_o[1]) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/fw_err_sched.sv
// Sequences fixed-weight error-vector generation with collision retry,
// then arbitrates consumer reads of the finished e1/e0 memories.
module fw_err_sched
   import fw_err_sched_pkg::*;
#(
   parameter int unsigned m         = M_DEF,
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned E0_WIDTH  = E0_WIDTH_DEF,
   parameter int unsigned E0_DEPTH  = E0_DEPTH_DEF,
   parameter int unsigned TAU       = TAU_DEF,
   parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
   parameter int unsigned LOGW      = $clog2(DEPTH),
   parameter int unsigned LOGE0W    = $clog2(E0_DEPTH)
) (
   input logic           clk,
   input logic           rst,
   fw_err_sched_if.slave bus
);

   // Elaboration guard: weight must fit both memories and the location space.
   if (MAX_RETRY == 0 || MAX_RETRY >= (1 << RETRY_W) || TAU == 0 ||
       TAU > WIDTH * DEPTH || TAU > E0_WIDTH * E0_DEPTH || TAU >= (1 << m) ||
       LOGW < $clog2(DEPTH) || LOGE0W < $clog2(E0_DEPTH)) begin : g_bad_cfg
      $error("fw_err_sched: inconsistent parameter set");
   end

   state_e             state_q, state_d;
   logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
   logic               coll_q, coll_edge;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic               fail_q, fail_d;
   logic               init_q, init_d;
   logic               start_q, start_d;
   logic               c0_rvalid_q, c1_rvalid_q;
   logic [1:0]         gnt;

   assign coll_edge = bus.gen_collision_i & ~coll_q;
   assign retry_inc = (retry_q >= RETRY_W'(MAX_RETRY)) ? RETRY_W'(MAX_RETRY)
                                                       : retry_q + RETRY_W'(1);

   // Next-state and retry bookkeeping; a collision edge outranks gen_done.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_i) begin
               state_d = ST_INIT;
               retry_d = '0;
            end
         end
         ST_INIT:     state_d = ST_WAIT_RDY;
         ST_WAIT_RDY: if (bus.gen_ready_i) state_d = ST_START;
         ST_START:    state_d = ST_GEN;
         ST_GEN: begin
            if (coll_edge) begin
               retry_d = retry_inc;
               state_d = (retry_inc < RETRY_W'(MAX_RETRY)) ? ST_WAIT_RDY : ST_FAIL;
            end else if (bus.gen_done_i) begin
               state_d = ST_VALID;
            end
         end
         ST_VALID: if (bus.release_i) state_d = ST_IDLE;
         ST_FAIL: begin
            if (bus.req_i) begin
               state_d = ST_INIT;
               retry_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the upcoming state so they register in step with it.
   always_comb begin
      busy_d  = 1'b0;
      valid_d = 1'b0;
      fail_d  = 1'b0;
      init_d  = 1'b0;
      start_d = 1'b0;
      case (state_d)
         ST_INIT: begin
            busy_d = 1'b1;
            init_d = 1'b1;
         end
         ST_WAIT_RDY, ST_GEN: busy_d = 1'b1;
         ST_START: begin
            busy_d  = 1'b1;
            start_d = 1'b1;
         end
         ST_VALID: valid_d = 1'b1;
         ST_FAIL:  fail_d  = 1'b1;
         default:  busy_d  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         retry_q <= '0;
         coll_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         fail_q  <= 1'b0;
         init_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         coll_q  <= bus.gen_collision_i;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         fail_q  <= fail_d;
         init_q  <= init_d;
         start_q <= start_d;
      end
   end

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (valid_q),
      .req_i ({bus.c1_req_i, bus.c0_req_i}),
      .gnt_o (gnt)
   );

   // Read data returns one cycle after the grant, even across a release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c0_rvalid_q <= 1'b0;
         c1_rvalid_q <= 1'b0;
      end else begin
         c0_rvalid_q <= gnt[0];
         c1_rvalid_q <= gnt[1];
      end
   end

   assign bus.busy_o         = busy_q;
   assign bus.vec_valid_o    = valid_q;
   assign bus.fail_o         = fail_q;
   assign bus.retry_cnt_o    = retry_q;
   assign bus.gen_init_mem_o = init_q;
   assign bus.gen_start_o    = start_q;
   assign bus.loc_reseed_o   = start_q;
   assign bus.c0_gnt_o       = gnt[0];
   assign bus.c1_gnt_o       = gnt[1];
   assign bus.c0_rvalid_o    = c0_rvalid_q;
   assign bus.c1_rvalid_o    = c1_rvalid_q;
   assign bus.rd_e_1_o       = |gnt;
   assign bus.rd_addr_e_1_o  = gnt[1] ? bus.c1_addr_i : (gnt[0] ? bus.c0_addr_i : '0);
   assign bus.rd_e_0_o       = bus.e0_req_i & valid_q;
   assign bus.rd_addr_e_0_o  = valid_q ? bus.e0_addr_i : '0;

endmodule

// File: doc/fw_err_sched.md
FW_ERR_SCHED -- requirements
Module: fw_err_sched

Interface
REQ-001 SHALL have parameters: m=13, location width; WIDTH=32, e1 word width; DEPTH=144, e1 words; E0_WIDTH=32, e0 word width; E0_DEPTH=144, e0 words; TAU=96, weight; MAX_RETRY=15, collision retries before fail; LOGW=clog2(DEPTH); LOGE0W=clog2(E0_DEPTH).
REQ-002 SHALL have ports, clock and reset first (name direction width meaning):
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request one fresh fixed-weight vector.
- release  in  1  consumers finished; vector may be discarded.
- busy  out  1  generation in progress.
- vec_valid  out  1  error memories hold a valid vector.
- fail  out  1  retry limit hit; sticky until next req.
- retry_cnt  out  4  collisions seen in current job.
- gen_init_mem  out  1  one-cycle init pulse to generator.
- gen_start  out  1  one-cycle start pulse to generator.
- loc_reseed  out  1  one-cycle pulse to location source on every (re)start.
- gen_ready, gen_done, gen_collision  in  1 each  generator status.
- c0_req, c1_req  in  1 each  e1 read requests, client 0 (encrypt), client 1 (hash).
- c0_addr, c1_addr  in  LOGW each  e1 word addresses.
- c0_gnt, c1_gnt  out  1 each  grant this cycle.
- c0_rvalid, c1_rvalid  out  1 each  read data valid.
- rd_e_1  out  1; rd_addr_e_1  out  LOGW  generator e1 read port.
- e0_req  in  1; e0_addr  in  LOGE0W  client 0 e0 read, no arbitration.
- rd_e_0  out  1; rd_addr_e_0  out  LOGE0W  generator e0 read port.

Function
REQ-003 SHALL implement FSM IDLE, INIT, WAIT_RDY, START, GEN, VALID, FAIL.
REQ-004 IDLE: req=1 -> INIT, clear retry_cnt and fail; busy=1 in every state except IDLE, VALID, FAIL.
REQ-005 INIT: assert gen_init_mem one cycle -> WAIT_RDY.
REQ-006 WAIT_RDY: gen_ready=1 -> START; no timeout.
REQ-007 START: assert gen_start and loc_reseed one cycle together -> GEN.
REQ-008 GEN: gen_done=1 -> VALID; gen_collision rising edge -> retry_cnt+1, then WAIT_RDY if new count < MAX_RETRY, else FAIL; if gen_done and collision edge occur in the same cycle, collision wins.
REQ-009 retry_cnt SHALL saturate at MAX_RETRY and never wrap.
REQ-010 VALID: vec_valid=1; release=1 -> IDLE, with vec_valid low the next cycle; req in VALID ignored until release.
REQ-011 FAIL: fail=1, vec_valid=0; req=1 -> INIT with fail and retry_cnt cleared.
REQ-012 Reads SHALL be granted only while vec_valid=1; outside VALID, all gnt, rd_e_* and rvalid SHALL be 0.
REQ-013 e1 arbiter SHALL be round-robin, one grant per cycle; single requester is granted immediately; on a tie the client not granted last wins; after reset, client 0 has priority.
REQ-014 Granted client's address SHALL drive rd_addr_e_1 with rd_e_1=1 in the grant cycle; the matching cN_rvalid SHALL assert exactly 1 cycle later (memory latency 1).
REQ-015 e0 path: rd_e_0=e0_req and vec_valid; rd_addr_e_0=e0_addr; combinational passthrough.
REQ-016 Grant outputs SHALL be combinational from req and the registered priority pointer; rvalid SHALL be registered.
REQ-017 An rvalid pending when release is taken SHALL still be delivered in the next cycle.

Reset
REQ-018 On rst=1 asynchronously: state=IDLE; all outputs 0; retry_cnt=0; RR pointer to client 0; pending rvalid cleared.
REQ-019 Reset mid-GEN SHALL abandon the job; after deassertion, no pulses until a new req.

Structure
REQ-020 A shared package SHALL hold the state enumeration, MAX_RETRY default, and the McEliece parameter constants (m, TAU, WIDTH, DEPTH).
REQ-021 The e1 round-robin arbiter SHALL be one sub-module, rr_arb2; all other logic stays flat.

Verification
REQ-022 Clean run: req pulse, gen_ready after 144 cycles, gen_done after 200 -> exactly one gen_init_mem, one gen_start, one loc_reseed; vec_valid=1; retry_cnt=0.
REQ-023 Collision retry: 3 collision edges, then done -> retry_cnt=3, loc_reseed count=4, vec_valid=1.
REQ-024 Fail: 15 collisions -> fail=1, busy=0, no further gen_start; next req clears fail.
REQ-025 Arbitration: c0_req and c1_req both held 6 cycles, c0_addr=5, c1_addr=9 -> grants alternate 0,1,0,1,0,1; rd_addr_e_1 alternates 5,9; each rvalid lags its gnt by 1.
REQ-026 Gating/reset: c1_req during GEN -> no grant; rst pulse during GEN -> outputs 0 immediately, IDLE held until req.
